sc_fifo_wm: RTL and testbench
=============================

// Module: sc_fifo_wm
// PURPOSE
//  Parametrised single-clock FIFO, the next generation of the ILA capture buffer.
//  Uses the full 2^AW depth, selectable standard/FWFT read mode, programmable
//  almost thresholds, sticky overflow/underflow flags, peak-occupancy watermark, sync flush.
//  Sits between trigger/sample logic and the readout interface.
// PARAMETERS
//  AW          5   address width; DEPTH = 2**AW entries
//  DW          64  data width in bits
//  AF_LEVEL    22  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    4   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT        0   0 = standard (registered dout, 1-cycle read latency); 1 = first-word-fall-through
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     synchronous clear of contents/status (priority over wr/rd)
//  din          in   DW    write data
//  wr           in   1     write request
//  full         out  1     count == DEPTH
//  almost_full  out  1     count >= AF_LEVEL
//  rd           in   1     read (pop) request
//  dout         out  DW    read data (see mode rules)
//  empty        out  1     count == 0
//  almost_empty out  1     count <= AE_LEVEL
//  fifo_cntr    out  AW+1  current occupancy 0..DEPTH
//  max_cntr     out  AW+1  highest fifo_cntr since reset/flush/wm_clr
//  wm_clr       in   1     synchronous clear of max_cntr to current fifo_cntr
//  overflow     out  1     sticky: wr while full without accepted rd same cycle
//  underflow    out  1     sticky: rd while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): ptrs=0, fifo_cntr=0, max_cntr=0, dout=0, overflow=0,
//    underflow=0 -> empty=1, almost_empty=1, full=0, almost_full=0. Memory not cleared.
//  - valid_rd = rd & ~empty. valid_wr = wr & (~full | valid_rd): write while full
//    accepted only with a same-cycle pop.
//  - Ptrs AW bits, wrap DEPTH-1 -> 0 naturally. fifo_cntr: +1 on wr only, -1 on rd
//    only, unchanged on both/neither. Never exceeds DEPTH, never below 0.
//  - Status flags decode registered fifo_cntr combinationally; they change only
//    the cycle after the causing edge.
//  - Standard mode (FWFT=0): on valid_rd, dout <= mem[rd_ptr]; held otherwise.
//    Data visible one cycle after rd. Write-then-read of one word: rd allowed
//    cycle after write (empty deasserted), dout valid cycle after that.
//  - FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally; valid whenever
//    empty=0; rd acknowledges/pops. dout undefined-content when empty (no X
//    propagation required, memory-initialised to 0 in sim).
//  - Simultaneous wr+rd when empty: write accepted, read rejected (underflow set).
//  - overflow <= 1 when wr & ~valid_wr; underflow <= 1 when rd & empty. Stay set
//    until reset or flush.
//  - max_cntr: each cycle, if next fifo_cntr > max_cntr then max_cntr <= next
//    fifo_cntr. wm_clr loads max_cntr <= fifo_cntr (current value).
//  - flush=1: ptrs, fifo_cntr, max_cntr, overflow, underflow -> 0 next edge;
//    wr/rd that cycle ignored (no flag updates); dout holds its value.
//  - Sim-only $display warnings on write-while-full and read-while-empty.
// TESTING
//  - Reset: drop rst_n mid-burst with no clock edge -> outputs at reset values immediately.
//  - Fill AW=4: 16 writes 0..15 -> full=1 after 16th, fifo_cntr=16, max_cntr=16;
//    17th wr -> rejected, overflow=1.
//  - Drain FWFT=0: 16 reads -> dout 0..15 each 1 cycle after rd; 17th rd -> underflow=1, dout holds 15.
//  - FWFT=1: write 0xA5 -> next cycle empty=0, dout=0xA5 without rd; rd -> empty=1.
//  - Full + wr&rd same cycle -> write accepted, fifo_cntr stays 16, no overflow;
//    pointer wrap verified over 40 writes/reads data-in-order.
//  - Thresholds AF=12, AE=3: almost_full at cntr 12, almost_empty off at 4;
//    flush at cntr 9 -> cntr=0, flags/max_cntr cleared, wr that cycle dropped.

Source files
------------

// File: rtl/sc_fifo_wm_if.sv
// Write/read handshake and status bundle of the sc_fifo_wm capture FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface sc_fifo_wm_if #(
    parameter int DW = 64
);
    logic [DW-1:0] din;
    logic          wr;
    logic          full;
    logic          almost_full;
    logic          rd;
    logic [DW-1:0] dout;
    logic          empty;
    logic          almost_empty;

    modport master (
        output din, wr, rd,
        input  dout, full, almost_full, empty, almost_empty
    );

    modport slave (
        input  din, wr, rd,
        output dout, full, almost_full, empty, almost_empty
    );
endinterface

// File: rtl/sc_fifo_wm.sv
// Single-clock FIFO using the full 2**AW depth, standard or FWFT read mode,
// almost thresholds, sticky overflow/underflow and a peak-occupancy watermark.
module sc_fifo_wm #(
    parameter int AW       = 5,
    parameter int DW       = 64,
    parameter int AF_LEVEL = 22,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wm_clr,
    sc_fifo_wm_if.slave   bus,
    output logic [AW:0]   fifo_cntr,
    output logic [AW:0]   max_cntr,
    output logic          overflow,
    output logic          underflow
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    // Handshake: a write is taken when wr=1 and either there is room or a pop
    // happens in the same cycle; a read is taken when rd=1 and empty=0.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty_i;
    logic          full_i;
    logic          valid_rd;
    logic          valid_wr;
    logic [AW:0]   cntr_next;

    assign empty_i          = (fifo_cntr == '0);
    assign full_i           = (fifo_cntr == DEPTH_C);
    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.almost_full  = (fifo_cntr >= AF_C);
    assign bus.almost_empty = (fifo_cntr <= AE_C);

    always_comb begin
        valid_rd  = bus.rd & ~empty_i;
        valid_wr  = bus.wr & (~full_i | valid_rd);
        cntr_next = fifo_cntr;
        if (valid_wr & ~valid_rd)
            cntr_next = fifo_cntr + (AW+1)'(1);
        else if (valid_rd & ~valid_wr)
            cntr_next = fifo_cntr - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (valid_wr & ~flush)
            mem[wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cntr <= '0;
            max_cntr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cntr <= '0;
            max_cntr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (valid_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (valid_rd)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_cntr <= cntr_next;
            // An explicit watermark clear takes precedence over peak tracking.
            if (wm_clr)
                max_cntr <= fifo_cntr;
            else if (cntr_next > max_cntr)
                max_cntr <= cntr_next;
            if (bus.wr & ~valid_wr)
                overflow <= 1'b1;
            if (bus.rd & empty_i)
                underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = mem[rd_ptr];
        end else begin : g_std
            logic [DW-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dout_q <= '0;
                else if (valid_rd & ~flush)
                    dout_q <= mem[rd_ptr];
            end
            assign bus.dout = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_sc_fifo_wm.sv
// Directed bench for sc_fifo_wm: a standard-mode instance and an FWFT instance,
// both AW=4 / DW=16 / AF=12 / AE=3, checked against a queue of expected words.
module tb_sc_fifo_wm;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: standard mode ----------------
    sc_fifo_wm_if #(.DW(DW)) a_if ();
    logic          a_flush;
    logic          a_wm_clr;
    logic [AW:0]   a_cntr;
    logic [AW:0]   a_max;
    logic          a_ovf;
    logic          a_udf;

    sc_fifo_wm #(.AW(AW), .DW(DW), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (a_flush),
        .wm_clr    (a_wm_clr),
        .bus       (a_if.slave),
        .fifo_cntr (a_cntr),
        .max_cntr  (a_max),
        .overflow  (a_ovf),
        .underflow (a_udf)
    );

    // ---------------- DUT B: FWFT mode ----------------
    sc_fifo_wm_if #(.DW(DW)) b_if ();
    logic          b_flush;
    logic          b_wm_clr;
    logic [AW:0]   b_cntr;
    logic [AW:0]   b_max;
    logic          b_ovf;
    logic          b_udf;

    sc_fifo_wm #(.AW(AW), .DW(DW), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .wm_clr    (b_wm_clr),
        .bus       (b_if.slave),
        .fifo_cntr (b_cntr),
        .max_cntr  (b_max),
        .overflow  (b_ovf),
        .underflow (b_udf)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] last_rd;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks (entered and left at negedge) ----------------
    task automatic a_cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                           input logic fl, input logic wc);
        a_if.wr  = wr;
        a_if.rd  = rd;
        a_if.din = d;
        a_flush  = fl;
        a_wm_clr = wc;
        @(posedge clk);
        @(negedge clk);
        a_if.wr  = 1'b0;
        a_if.rd  = 1'b0;
        a_flush  = 1'b0;
        a_wm_clr = 1'b0;
    endtask

    task automatic a_write(input logic [DW-1:0] d);
        a_cycle(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    // Pops one word and compares the registered dout one cycle later.
    task automatic a_read_chk(input string tag);
        a_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        check(tag, a_if.dout, exp_w);
        last_rd = exp_w;
    endtask

    task automatic b_cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
        b_if.wr  = wr;
        b_if.rd  = rd;
        b_if.din = d;
        @(posedge clk);
        @(negedge clk);
        b_if.wr  = 1'b0;
        b_if.rd  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        a_if.wr  = 1'b0; a_if.rd = 1'b0; a_if.din = '0;
        b_if.wr  = 1'b0; b_if.rd = 1'b0; b_if.din = '0;
        a_flush  = 1'b0; a_wm_clr = 1'b0;
        b_flush  = 1'b0; b_wm_clr = 1'b0;
        last_rd  = '0;

        #2;
        check("rst_empty",  a_if.empty, 1);
        check("rst_ae",     a_if.almost_empty, 1);
        check("rst_full",   a_if.full, 0);
        check("rst_af",     a_if.almost_full, 0);
        check("rst_cntr",   a_cntr, 0);
        check("rst_max",    a_max, 0);
        check("rst_ovf",    a_ovf, 0);
        check("rst_udf",    a_udf, 0);
        check("rst_dout",   a_if.dout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0..15, watching thresholds along the way.
        for (int i = 0; i < 16; i++) begin
            a_write(DW'(i));
            exp_q.push_back(DW'(i));
            check("fill_cntr", a_cntr, i + 1);
            check("fill_ae",   a_if.almost_empty, (i + 1 <= 3) ? 1 : 0);
            check("fill_af",   a_if.almost_full, (i + 1 >= 12) ? 1 : 0);
        end
        check("full_flag", a_if.full, 1);
        check("full_max",  a_max, 16);
        check("full_ovf",  a_ovf, 0);

        // Write while full with a same-cycle pop is accepted.
        a_cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
        exp_q.push_back(16'h0100);
        exp_w = exp_q.pop_front();
        check("wrrd_full_dout", a_if.dout, exp_w);
        check("wrrd_full_cntr", a_cntr, 16);
        check("wrrd_full_ovf",  a_ovf, 0);

        // Plain write while full is rejected and sets overflow.
        a_write(16'hDEAD);
        check("ovf_flag", a_ovf, 1);
        check("ovf_cntr", a_cntr, 16);

        for (int i = 0; i < 16; i++) a_read_chk("drain_dout");
        check("drain_empty", a_if.empty, 1);
        check("drain_cntr",  a_cntr, 0);
        check("drain_max",   a_max, 16);

        a_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("udf_flag", a_udf, 1);
        check("udf_dout_hold", a_if.dout, 16'h0100);

        a_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("flush_ovf",  a_ovf, 0);
        check("flush_udf",  a_udf, 0);
        check("flush_max",  a_max, 0);
        check("flush_dout", a_if.dout, 16'h0100);

        // Pointer wrap: 40 writes / 40 reads, random data kept in order.
        for (int i = 0; i < 5; i++) begin
            exp_w = DW'($urandom_range(0, 16'hFFFF));
            a_write(exp_w);
            exp_q.push_back(exp_w);
        end
        for (int i = 0; i < 35; i++) begin
            exp_w = DW'($urandom_range(0, 16'hFFFF));
            exp_q.push_back(exp_w);
            a_cycle(1'b1, 1'b1, exp_w, 1'b0, 1'b0);
            exp_w = exp_q.pop_front();
            check("wrap_dout", a_if.dout, exp_w);
            last_rd = exp_w;
            check("wrap_cntr", a_cntr, 5);
        end
        for (int i = 0; i < 5; i++) a_read_chk("wrap_drain");
        check("wrap_max", a_max, 5);

        a_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("wmclr_max", a_max, 0);

        // wr+rd while empty: write taken, read rejected.
        a_cycle(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
        exp_q.push_back(16'h0077);
        check("wrrd_empty_cntr", a_cntr, 1);
        check("wrrd_empty_udf",  a_udf, 1);
        check("wrrd_empty_dout", a_if.dout, last_rd);
        a_read_chk("wrrd_empty_data");

        // Flush at occupancy 9 with a write in the same cycle.
        for (int i = 0; i < 9; i++) a_write(DW'(16'h0200 + i));
        check("pre_flush_cntr", a_cntr, 9);
        check("pre_flush_max",  a_max, 9);
        a_cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        check("flush9_cntr",  a_cntr, 0);
        check("flush9_empty", a_if.empty, 1);
        check("flush9_ae",    a_if.almost_empty, 1);
        check("flush9_max",   a_max, 0);
        check("flush9_udf",   a_udf, 0);
        check("flush9_dout",  a_if.dout, 16'h0077);
        a_write(16'h0055);
        exp_q.push_back(16'h0055);
        check("post_flush_cntr", a_cntr, 1);
        a_read_chk("post_flush_data");

        // Async reset mid-burst, checked before any further clock edge.
        a_if.wr = 1'b1; a_if.din = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        a_if.din = 16'h0002;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cntr",  a_cntr, 0);
        check("arst_empty", a_if.empty, 1);
        check("arst_dout",  a_if.dout, 0);
        check("arst_max",   a_max, 0);
        a_if.wr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // FWFT instance: data visible without a read.
        b_cycle(1'b1, 1'b0, 16'h00A5);
        exp_q.push_back(16'h00A5);
        b_cycle(1'b1, 1'b0, 16'h003C);
        exp_q.push_back(16'h003C);
        check("fwft_empty", b_if.empty, 0);
        check("fwft_cntr",  b_cntr, 2);
        check("fwft_head",  b_if.dout, exp_q[0]);
        b_cycle(1'b0, 1'b1, '0);
        void'(exp_q.pop_front());
        check("fwft_next", b_if.dout, exp_q[0]);
        b_cycle(1'b0, 1'b1, '0);
        void'(exp_q.pop_front());
        check("fwft_empty_after", b_if.empty, 1);
        check("fwft_udf_clear",   b_udf, 0);
        b_cycle(1'b0, 1'b1, '0);
        check("fwft_udf", b_udf, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
